// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter.
//   arbState_e      : arbiter FSM encoding (also visible on the debug port)
//   DEFAULT_TIMEOUT : default watchdog limit in busy cycles
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arbState_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Watchdog for one outstanding bus transaction.
//   clk, rst : clock, synchronous active-high reset
//   start    : transaction issued this cycle (clears and arms the counter)
//   stop     : transaction finished this cycle (ack or abort; disarms)
//   expire   : one-cycle pulse in the TIMEOUT-th busy cycle without stop
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter reads 0 in the first busy cycle, so the TIMEOUT-th busy
  // cycle is the one where it holds TIMEOUT-1.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;
  logic          running;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (stop) begin
      count   <= '0;
      running <= 1'b0;
    end else if (running) begin
      count   <= count + 1'b1;
    end
  end

  // Once expire fires the owner completes and raises stop, so the pulse
  // lasts exactly one cycle.
  assign expire = running && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/acknowledge memory bus between the IF and MEM stages.
// Data accesses win over fetches; one transaction is outstanding at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   if_req/if_addr           : fetch request, held until if_ready or flush
//   if_rdata/if_ready/if_err : fetch result, one-cycle ready pulse
//   flush                    : discard the fetch in flight (or not yet issued)
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb : data request, held until dm_ready
//   dm_rdata/dm_ready/dm_err : data result, one-cycle ready pulse
//   bus_*                    : registered bus command, held until ack/abort
//   bus_ack/bus_rdata        : memory completion pulse and read data
//   dbgState                 : current FSM state, for observation only
//
// Handshake: a requester raises *_req with a stable command and holds it
// until the matching one-cycle *_ready; the arbiter ignores a port's *_req in
// that port's own ready cycle. On the bus side bus_req and the command stay
// stable until a one-cycle bus_ack (or the watchdog aborts); an ack arriving
// while no transaction is outstanding is ignored.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_err,
  input  logic                flush,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                dm_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [1:0]          dbgState
);

  arbState_e state, stateNext;
  logic      grantDm, grantIf, complete;
  logic      discard;
  logic      expire;
  logic      ifDeliver, dmDeliver, timedOut;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (grantDm || grantIf),
    .stop   (complete),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and grant/complete strobes. A port still showing its own
  // ready pulse is holding a request that has already been served.
  always_comb begin
    stateNext = state;
    grantDm   = 1'b0;
    grantIf   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !dm_ready) begin
          grantDm   = 1'b1;
          stateNext = DM_BUSY;
        end else if (if_req && !flush && !if_ready) begin
          grantIf   = 1'b1;
          stateNext = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (bus_ack || expire) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // An ack in the expiry cycle still counts as a normal completion.
  assign timedOut  = !bus_ack;
  assign ifDeliver = complete && (state == IF_BUSY) && !(discard || flush);
  assign dmDeliver = complete && (state == DM_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      if_err    <= 1'b0;
      dm_rdata  <= '0;
      dm_ready  <= 1'b0;
      dm_err    <= 1'b0;
      discard   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      if_err   <= 1'b0;
      dm_ready <= 1'b0;
      dm_err   <= 1'b0;

      if (grantDm) begin
        bus_req   <= 1'b1;
        bus_we    <= dm_we;
        bus_addr  <= dm_addr;
        bus_wdata <= dm_wdata;
        bus_wstrb <= dm_wstrb;
      end else if (grantIf) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_wstrb <= '0;
        discard   <= 1'b0;
      end

      // The bus cannot be cancelled, so a flushed fetch is only marked and
      // its result dropped when it completes.
      if ((state == IF_BUSY) && flush && !complete) begin
        discard <= 1'b1;
      end

      if (complete) begin
        bus_req <= 1'b0;
        discard <= 1'b0;
      end

      if (ifDeliver) begin
        if_ready <= 1'b1;
        if_err   <= timedOut;
        if_rdata <= timedOut ? '0 : bus_rdata;
      end

      // Store data returns nothing, so rdata reads 0 for stores.
      if (dmDeliver) begin
        dm_ready <= 1'b1;
        dm_err   <= timedOut;
        dm_rdata <= (timedOut || bus_we) ? '0 : bus_rdata;
      end
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          if_err;
  logic          flush;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [SW-1:0] dm_wstrb;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          dm_err;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [SW-1:0] bus_wstrb;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic [1:0]    dbgState;

  int errors = 0;
  int checks = 0;
  int violations = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_err(if_err), .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .dm_err(dm_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .dbgState(dbgState)
  );

  // Properties that must hold in every cycle.
  always @(negedge clk) begin
    if (!rst && ((if_ready && dm_ready) || (if_err && !if_ready) || (dm_err && !dm_ready)))
      violations++;
  end

  // Advance one cycle; inputs driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = '0; flush = 0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; bus_ack = 0; bus_rdata = '0;
    tick(); tick();
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
      errors++; $display("FAIL reset_bus: got req=%b addr=%h wdata=%h, want all 0", bus_req, bus_addr, bus_wdata);
    end
    checks++;
    if ({if_ready, dm_ready, if_err, dm_err, if_rdata, dm_rdata, dbgState} !== '0) begin
      errors++; $display("FAIL reset_ports: got if_rdy=%b dm_rdy=%b if_rdata=%h dm_rdata=%h state=%0d, want 0",
                         if_ready, dm_ready, if_rdata, dm_rdata, dbgState);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    tick(); // cycle 1
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 || dbgState !== 2'd2) begin
      errors++; $display("FAIL load_issue: got req=%b addr=%h we=%b state=%0d, want 1/100/0/2", bus_req, bus_addr, bus_we, dbgState);
    end
    tick(); // cycle 2
    checks++;
    if (dm_ready !== 1'b0 || bus_req !== 1'b1) begin
      errors++; $display("FAIL load_wait: got dm_ready=%b bus_req=%b, want 0/1", dm_ready, bus_req);
    end
    tick(); // cycle 3: memory acks
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick(); // cycle 4: ready pulse, requester still holding dm_req
    bus_ack = 0;
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEADBEEF || dm_err !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL load_ready: got rdy=%b rdata=%h err=%b bus_req=%b, want 1/deadbeef/0/0", dm_ready, dm_rdata, dm_err, bus_req);
    end
    tick(); // cycle 5: held request in ready cycle must not be re-granted
    dm_req = 0;
    checks++;
    if (dm_ready !== 1'b0 || bus_req !== 1'b0 || dbgState !== 2'd0) begin
      errors++; $display("FAIL load_no_regrant: got rdy=%b bus_req=%b state=%0d, want 0/0/0", dm_ready, bus_req, dbgState);
    end
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    tick(); // c1
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h300 || dbgState !== 2'd2) begin
      errors++; $display("FAIL cont_dm_first: got req=%b addr=%h state=%0d, want 1/300/2", bus_req, bus_addr, dbgState);
    end
    bus_ack = 1; bus_rdata = 32'hAAAA0001;
    tick(); // c2: dm_ready; fetch grant registered at the end of this cycle
    bus_ack = 0;
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'hAAAA0001 || if_ready !== 1'b0) begin
      errors++; $display("FAIL cont_dm_ready: got dm_rdy=%b rdata=%h if_rdy=%b, want 1/aaaa0001/0", dm_ready, dm_rdata, if_ready);
    end
    tick(); // c3
    dm_req = 0;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_we !== 1'b0 || bus_wstrb !== 4'b0 || dbgState !== 2'd1) begin
      errors++; $display("FAIL cont_if_issue: got req=%b addr=%h we=%b strb=%b state=%0d, want 1/200/0/0/1",
                         bus_req, bus_addr, bus_we, bus_wstrb, dbgState);
    end
    bus_ack = 1; bus_rdata = 32'h13;
    tick(); // c4: if_ready two cycles after dm_ready
    bus_ack = 0;
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h13 || if_err !== 1'b0 || dm_ready !== 1'b0) begin
      errors++; $display("FAIL cont_if_ready: got if_rdy=%b rdata=%h err=%b dm_rdy=%b, want 1/13/0/0", if_ready, if_rdata, if_err, dm_ready);
    end
    tick(); // c5
    if_req = 0;
    checks++;
    if (bus_req !== 1'b0 || if_ready !== 1'b0) begin
      errors++; $display("FAIL cont_if_no_regrant: got bus_req=%b if_rdy=%b, want 0/0", bus_req, if_ready);
    end
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 32'h40;
    tick(); // c1: fetch issued
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h40 || dbgState !== 2'd1) begin
      errors++; $display("FAIL flush_issue: got req=%b addr=%h state=%0d, want 1/40/1", bus_req, bus_addr, dbgState);
    end
    tick(); // c2
    flush = 1; if_req = 0;
    tick(); // c3
    flush = 0;
    tick(); // c4
    bus_ack = 1; bus_rdata = 32'hBAD;
    tick(); // c5
    bus_ack = 0;
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h13 || bus_req !== 1'b0 || dbgState !== 2'd0) begin
      errors++; $display("FAIL flush_discard: got if_rdy=%b rdata=%h bus_req=%b state=%0d, want 0/13/0/0",
                         if_ready, if_rdata, bus_req, dbgState);
    end
    if_req = 1; if_addr = 32'h80;
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h80) begin
      errors++; $display("FAIL flush_refetch_issue: got req=%b addr=%h, want 1/80", bus_req, bus_addr);
    end
    bus_ack = 1; bus_rdata = 32'h80808080;
    tick();
    bus_ack = 0;
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h80808080 || if_err !== 1'b0) begin
      errors++; $display("FAIL flush_refetch_ready: got rdy=%b rdata=%h err=%b, want 1/80808080/0", if_ready, if_rdata, if_err);
    end
    tick();
    if_req = 0;
    // Flush in IDLE blocks the grant; flush in the ack cycle suppresses ready.
    if_req = 1; if_addr = 32'h44; flush = 1;
    tick();
    flush = 0;
    checks++;
    if (bus_req !== 1'b0 || dbgState !== 2'd0) begin
      errors++; $display("FAIL flush_idle_block: got bus_req=%b state=%0d, want 0/0", bus_req, dbgState);
    end
    tick();
    bus_ack = 1; bus_rdata = 32'h5; flush = 1; if_req = 0;
    tick();
    bus_ack = 0; flush = 0;
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h80808080 || dbgState !== 2'd0) begin
      errors++; $display("FAIL flush_at_ack: got rdy=%b rdata=%h state=%0d, want 0/80808080/0", if_ready, if_rdata, dbgState);
    end
    tick();
  endtask

  task automatic test_store();
    dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h1234; dm_wstrb = 4'b0011;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h500 || bus_wdata !== 32'h1234 || bus_wstrb !== 4'b0011) begin
        errors++; $display("FAIL store_hold_%0d: got req=%b we=%b addr=%h wdata=%h strb=%b, want 1/1/500/1234/0011",
                           i, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
      end
    end
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_ack = 0;
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'h0 || dm_err !== 1'b0 || if_ready !== 1'b0) begin
      errors++; $display("FAIL store_ready: got rdy=%b rdata=%h err=%b if_rdy=%b, want 1/0/0/0", dm_ready, dm_rdata, dm_err, if_ready);
    end
    tick();
    dm_req = 0; dm_we = 0; dm_wstrb = '0; dm_wdata = '0;
    checks++;
    if (dm_ready !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL store_single_pulse: got rdy=%b bus_req=%b, want 0/0", dm_ready, bus_req);
    end
  endtask

  task automatic test_timeout();
    dm_req = 1; dm_we = 0; dm_addr = 32'h600;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus_req !== 1'b1 || dm_ready !== 1'b0) begin
        errors++; $display("FAIL timeout_busy_%0d: got bus_req=%b dm_rdy=%b, want 1/0", i, bus_req, dm_ready);
      end
    end
    bus_rdata = 32'hCAFECAFE;
    tick();
    checks++;
    if (bus_req !== 1'b0 || dm_ready !== 1'b1 || dm_err !== 1'b1 || dm_rdata !== 32'h0 || dbgState !== 2'd0) begin
      errors++; $display("FAIL timeout_abort: got bus_req=%b rdy=%b err=%b rdata=%h state=%0d, want 0/1/1/0/0",
                         bus_req, dm_ready, dm_err, dm_rdata, dbgState);
    end
    tick();
    dm_req = 0; bus_ack = 1;
    tick();
    bus_ack = 0;
    checks++;
    if (dm_ready !== 1'b0 || if_ready !== 1'b0 || bus_req !== 1'b0 || dm_err !== 1'b0 || dbgState !== 2'd0) begin
      errors++; $display("FAIL timeout_late_ack: got dm_rdy=%b if_rdy=%b bus_req=%b err=%b state=%0d, want 0/0/0/0/0",
                         dm_ready, if_ready, bus_req, dm_err, dbgState);
    end
  endtask

  task automatic test_reset_busy();
    dm_req = 1; dm_we = 0; dm_addr = 32'h700;
    tick();
    rst = 1;
    tick();
    rst = 0; dm_req = 0;
    checks++;
    if (bus_req !== 1'b0 || bus_addr !== '0 || dbgState !== 2'd0 || dm_ready !== 1'b0 || dm_rdata !== '0 || if_rdata !== '0) begin
      errors++; $display("FAIL rst_busy_values: got bus_req=%b addr=%h state=%0d rdy=%b dm_rdata=%h if_rdata=%h, want all 0",
                         bus_req, bus_addr, dbgState, dm_ready, dm_rdata, if_rdata);
    end
    bus_ack = 1; bus_rdata = 32'h77;
    tick();
    bus_ack = 0;
    checks++;
    if (dm_ready !== 1'b0 || if_ready !== 1'b0 || dm_rdata !== '0) begin
      errors++; $display("FAIL rst_busy_stale_ack: got dm_rdy=%b if_rdy=%b rdata=%h, want 0/0/0", dm_ready, if_ready, dm_rdata);
    end
    tick();
  endtask

  task automatic test_invariants();
    checks++;
    if (violations !== 0) begin
      errors++; $display("FAIL ready_err_invariants: got %0d violating cycles, want 0", violations);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_flush();
    test_store();
    test_timeout();
    test_reset_busy();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
